dispatch_queue: RTL and testbench

3-wide in-order dispatch buffer between decode and the reservation station (RS). Accepts up to three decoded instructions per cycle from decode and presents up to three per cycle in RS dispatch-slot format. Honours the RS `struct_stall` vector so that only the RS-accepted slots leave the queue. Drives `fetch_stall` back to decode and drops all contents on a squash.

---
 rtl/dispatch_queue.sv | 209 ++++++++++++++++++++
 tb/tb_dispatch_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_queue.sv
// dispatch_queue: 3-wide in-order buffer between decode and the reservation
// station. Circular storage of {inst, npc}. The first three entries are shown
// to the RS as dispatch slots 2 (oldest), 1 and 0, straight from registers.
// Optional build macro: DISPATCH_QUEUE_DISPLAY_EN adds the dq_entries_display
// and dq_count_display viewing ports.
module dispatch_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        squash,
  input  logic [2:0]  fetch_valid,
  input  logic [95:0] fetch_inst,
  input  logic [95:0] fetch_npc,
  output logic [2:0]  fetch_stall,
  output logic [2:0]  disp_valid,
  output logic [95:0] disp_inst,
  output logic [95:0] disp_npc,
  input  logic [2:0]  struct_stall
`ifdef DISPATCH_QUEUE_DISPLAY_EN
  ,
  output logic [DEPTH*65-1:0]       dq_entries_display,
  output logic [$clog2(DEPTH):0]    dq_count_display
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // storage and pointers
  logic [31:0]   r_inst [DEPTH];
  logic [31:0]   r_npc  [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // combinational helpers
  logic [CW-1:0] w_free;
  logic [2:0]    w_fetch_acc;
  logic [2:0]    w_disp_acc;
  logic [1:0]    w_enq;
  logic [1:0]    w_deq;
  logic [PW-1:0] w_rd0, w_rd1, w_rd2;
  logic [PW-1:0] w_wr0, w_wr1, w_wr2;

  // Free space uses only the registered count; same-cycle dequeues do not help.
  assign w_free = CW'(DEPTH) - r_count;

  assign w_rd0 = r_head;
  assign w_rd1 = r_head + PW'(1);
  assign w_rd2 = r_head + PW'(2);
  assign w_wr0 = r_tail;
  assign w_wr1 = r_tail + PW'(1);
  assign w_wr2 = r_tail + PW'(2);

  // Back-pressure to decode: thermometer from slot 0 as free space shrinks.
  always_comb begin
    fetch_stall = 3'b111;
    if (!reset) begin
      fetch_stall = 3'b000;
    end else if (squash) begin
      fetch_stall = 3'b111;
    end else if (w_free >= CW'(3)) begin
      fetch_stall = 3'b000;
    end else if (w_free == CW'(2)) begin
      fetch_stall = 3'b001;
    end else if (w_free == CW'(1)) begin
      fetch_stall = 3'b011;
    end else begin
      fetch_stall = 3'b111;
    end
  end

  assign w_fetch_acc = fetch_valid & ~fetch_stall;

  // Enqueue count: leading run of accepted fetch slots from slot 2; a hole ends it.
  always_comb begin
    w_enq = 2'd0;
    if (squash) begin
      w_enq = 2'd0;
    end else if (w_fetch_acc == 3'b111) begin
      w_enq = 2'd3;
    end else if (w_fetch_acc[2:1] == 2'b11) begin
      w_enq = 2'd2;
    end else if (w_fetch_acc[2]) begin
      w_enq = 2'd1;
    end else begin
      w_enq = 2'd0;
    end
  end

  // Dispatch valid: thermometer from slot 2 filled by occupancy, killed by squash.
  always_comb begin
    disp_valid = 3'b000;
    if (!reset || squash) begin
      disp_valid = 3'b000;
    end else if (r_count >= CW'(3)) begin
      disp_valid = 3'b111;
    end else if (r_count == CW'(2)) begin
      disp_valid = 3'b110;
    end else if (r_count == CW'(1)) begin
      disp_valid = 3'b100;
    end else begin
      disp_valid = 3'b000;
    end
  end

  // Dispatch payload: head-relative entries, zeroed on invalid slots.
  always_comb begin
    disp_inst = 96'd0;
    disp_npc  = 96'd0;
    if (disp_valid[2]) begin
      disp_inst[95:64] = r_inst[w_rd0];
      disp_npc[95:64]  = r_npc[w_rd0];
    end else begin
      disp_inst[95:64] = 32'd0;
      disp_npc[95:64]  = 32'd0;
    end
    if (disp_valid[1]) begin
      disp_inst[63:32] = r_inst[w_rd1];
      disp_npc[63:32]  = r_npc[w_rd1];
    end else begin
      disp_inst[63:32] = 32'd0;
      disp_npc[63:32]  = 32'd0;
    end
    if (disp_valid[0]) begin
      disp_inst[31:0] = r_inst[w_rd2];
      disp_npc[31:0]  = r_npc[w_rd2];
    end else begin
      disp_inst[31:0] = 32'd0;
      disp_npc[31:0]  = 32'd0;
    end
  end

  assign w_disp_acc = disp_valid & ~struct_stall;

  // Dequeue count: leading run of RS-accepted slots from slot 2.
  always_comb begin
    w_deq = 2'd0;
    if (w_disp_acc == 3'b111) begin
      w_deq = 2'd3;
    end else if (w_disp_acc[2:1] == 2'b11) begin
      w_deq = 2'd2;
    end else if (w_disp_acc[2]) begin
      w_deq = 2'd1;
    end else begin
      w_deq = 2'd0;
    end
  end

  // Entry storage: write accepted fetch slots in order 2,1,0 at tail, tail+1, tail+2.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= 32'd0;
        r_npc[i]  <= 32'd0;
      end
    end else if (!squash) begin
      if (w_enq >= 2'd1) begin
        r_inst[w_wr0] <= fetch_inst[95:64];
        r_npc[w_wr0]  <= fetch_npc[95:64];
      end
      if (w_enq >= 2'd2) begin
        r_inst[w_wr1] <= fetch_inst[63:32];
        r_npc[w_wr1]  <= fetch_npc[63:32];
      end
      if (w_enq == 2'd3) begin
        r_inst[w_wr2] <= fetch_inst[31:0];
        r_npc[w_wr2]  <= fetch_npc[31:0];
      end
    end
  end

  // Pointers and occupancy: enqueue and dequeue both apply; squash empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_enq);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

`ifdef DISPATCH_QUEUE_DISPLAY_EN
  // Viewing ports: each entry with an occupied flag derived from head/count.
  always_comb begin
    logic [PW-1:0] v_off;
    dq_entries_display = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_off = PW'(i) - r_head;
      if ({1'b0, v_off} < r_count) begin
        dq_entries_display[65*i +: 65] = {1'b1, r_inst[i], r_npc[i]};
      end else begin
        dq_entries_display[65*i +: 65] = {1'b0, r_inst[i], r_npc[i]};
      end
    end
  end

  assign dq_count_display = r_count;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed scenarios plus randomized traffic, checked
// against a queue-based reference model of the dispatch buffer.
module tb_dispatch_queue;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        squash;
  logic [2:0]  fetch_valid;
  logic [95:0] fetch_inst;
  logic [95:0] fetch_npc;
  logic [2:0]  fetch_stall;
  logic [2:0]  disp_valid;
  logic [95:0] disp_inst;
  logic [95:0] disp_npc;
  logic [2:0]  struct_stall;
`ifdef DISPATCH_QUEUE_DISPLAY_EN
  logic [DEPTH*65-1:0]    dq_entries_display;
  logic [$clog2(DEPTH):0] dq_count_display;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model: oldest entry at index 0, each {inst, npc}
  logic [63:0] q[$];
  logic [31:0] next_npc;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .squash       (squash),
    .fetch_valid  (fetch_valid),
    .fetch_inst   (fetch_inst),
    .fetch_npc    (fetch_npc),
    .fetch_stall  (fetch_stall),
    .disp_valid   (disp_valid),
    .disp_inst    (disp_inst),
    .disp_npc     (disp_npc),
    .struct_stall (struct_stall)
`ifdef DISPATCH_QUEUE_DISPLAY_EN
    ,
    .dq_entries_display (dq_entries_display),
    .dq_count_display   (dq_count_display)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // number of consecutive set bits starting at slot 2
  function automatic int run_len(input logic [2:0] v);
    int n;
    n = 0;
    for (int k = 2; k >= 0; k--) begin
      if (!v[k]) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [2:0] model_fstall(input int free);
    if (free >= 3) return 3'b000;
    if (free == 2) return 3'b001;
    if (free == 1) return 3'b011;
    return 3'b111;
  endfunction

  // One cycle: drive at negedge, check outputs, update model at posedge.
  task automatic step(input logic [2:0] fv, input logic [2:0] ss, input logic sq);
    logic [2:0]  efs, edv;
    logic [95:0] ei, en;
    logic [63:0] inc [3];
    int enq, deq, sz;
    fetch_valid  = fv;
    struct_stall = ss;
    squash       = sq;
    for (int k = 0; k < 3; k++) begin
      fetch_inst[32*k +: 32] = $urandom;
      fetch_npc[32*k +: 32]  = next_npc + 32'(4 * (2 - k));
    end
    #1;
    sz  = q.size();
    efs = sq ? 3'b111 : model_fstall(DEPTH - sz);
    edv = 3'b000;
    ei  = 96'd0;
    en  = 96'd0;
    if (!sq) begin
      for (int j = 0; j < 3 && j < sz; j++) begin
        edv[2-j]            = 1'b1;
        ei[32*(2-j) +: 32]  = q[j][63:32];
        en[32*(2-j) +: 32]  = q[j][31:0];
      end
    end
    check("fetch_stall", {93'd0, fetch_stall}, {93'd0, efs});
    check("disp_valid",  {93'd0, disp_valid},  {93'd0, edv});
    check("disp_inst",   disp_inst, ei);
    check("disp_npc",    disp_npc,  en);
    enq = sq ? 0 : run_len(fv & ~efs);
    deq = run_len(edv & ~ss);
    for (int j = 0; j < 3; j++) begin
      inc[j] = {fetch_inst[32*(2-j) +: 32], fetch_npc[32*(2-j) +: 32]};
    end
    @(posedge clock);
    if (sq) begin
      q.delete();
    end else begin
      repeat (deq) void'(q.pop_front());
      for (int j = 0; j < enq; j++) q.push_back(inc[j]);
      next_npc = next_npc + 32'(4 * enq);
    end
    @(negedge clock);
  endtask

  // Reset pulse between edges; squash held high to see fetch_stall forced low.
  task automatic do_reset();
    reset  = 1'b0;
    squash = 1'b1;
    #1;
    check("rst_fetch_stall", {93'd0, fetch_stall}, 96'd0);
    check("rst_disp_valid",  {93'd0, disp_valid},  96'd0);
    check("rst_disp_npc",    disp_npc, 96'd0);
    squash = 1'b0;
    #1;
    reset = 1'b1;
    q.delete();
    next_npc = 32'd4;
  endtask

  initial begin
    reset        = 1'b0;
    squash       = 1'b0;
    fetch_valid  = 3'b000;
    fetch_inst   = 96'd0;
    fetch_npc    = 96'd0;
    struct_stall = 3'b000;
    next_npc     = 32'd4;
    @(negedge clock);

    // basic 3-wide flow
    do_reset();
    step(3'b111, 3'b000, 1'b0);
    check("basic_npc", disp_npc, {32'd4, 32'd8, 32'd12});
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);

    // partial RS acceptance with 6 entries
    do_reset();
    step(3'b111, 3'b111, 1'b0);
    step(3'b111, 3'b111, 1'b0);
    step(3'b000, 3'b011, 1'b0);
    check("partial_npc", disp_npc, {32'd8, 32'd12, 32'd16});
    step(3'b000, 3'b010, 1'b0);
    step(3'b000, 3'b111, 1'b0);

    // fill to full, then release
    do_reset();
    step(3'b111, 3'b111, 1'b0);
    step(3'b111, 3'b111, 1'b0);
    step(3'b111, 3'b111, 1'b0);
    step(3'b111, 3'b000, 1'b0);
    step(3'b000, 3'b111, 1'b0);

    // wrap-around streaming
    do_reset();
    for (int c = 0; c < 10; c++) step(3'b111, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);

    // squash with concurrent traffic (5 entries held)
    do_reset();
    step(3'b111, 3'b111, 1'b0);
    step(3'b110, 3'b111, 1'b0);
    step(3'b111, 3'b000, 1'b1);
    step(3'b000, 3'b000, 1'b0);

    // async reset mid-stream (4 entries held)
    do_reset();
    step(3'b111, 3'b111, 1'b0);
    step(3'b100, 3'b111, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_disp_valid", {93'd0, disp_valid}, 96'd0);
    check("mid_rst_disp_inst",  disp_inst, 96'd0);
    @(posedge clock);
    #1;
    check("mid_rst_hold_valid", {93'd0, disp_valid}, 96'd0);
    @(negedge clock);
    reset = 1'b1;
    q.delete();
    next_npc = 32'd4;
    step(3'b000, 3'b000, 1'b0);
    step(3'b101, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
